vbuffer_write_arbiter: RTL and testbench

Shares the single write port of `vbuffer` between two pixel-write requesters, such as the host register interface and a fill engine. With `BLANK_ONLY` set, the write port is granted only while the raster is in blanking, so visible scanout never tears. Arbitration is round-robin with a burst limit, and the block drives the registered write strobe, address and data that feed `vbuffer`. It runs in the pixel clock domain, next to `vcounter` and `vbuffer`.

---
 rtl/vbuffer_write_arbiter_pkg.sv | 19 +
 rtl/vbuffer_write_arbiter.sv | 130 +++++++++++++
 tb/tb_vbuffer_write_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vbuffer_write_arbiter_pkg.sv
// Shared definitions for the vbuffer write-port arbiter: FSM encodings and
// the burst counter width, kept here so later display controllers can reuse them.
package vbuffer_write_arbiter_pkg;

    localparam int BCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arbState_t;

    // Saturating increment of the burst counter, capped at lim.
    function automatic logic [BCNT_W-1:0] satInc(input logic [BCNT_W-1:0] v,
                                                 input logic [BCNT_W-1:0] lim);
        return (v < lim) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/vbuffer_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing the single vbuffer write port
// between two requesters, optionally gated to the blanking window.
// Grants are combinational; the write strobe/address/data are registered.
module vbuffer_write_arbiter
    import vbuffer_write_arbiter_pkg::*;
#(
    parameter int AWIDTH     = 2,
    parameter int BPP        = 6,
    parameter bit BLANK_ONLY = 1'b1,
    parameter int BURST_MAX  = 4
) (
    input  logic              PixelClkSrc,
    input  logic              Rst,
    input  logic              Blank,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [AWIDTH-1:0] Req0Addr,
    input  logic [BPP-1:0]    Req0Data,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [AWIDTH-1:0] Req1Addr,
    input  logic [BPP-1:0]    Req1Data,
    output logic              WrEnable,
    output logic [AWIDTH-1:0] WrAddr,
    output logic [BPP-1:0]    WrData
);

    localparam logic [BCNT_W-1:0] BurstMaxC = BCNT_W'(BURST_MAX);

    arbState_t         state, stateNext;
    logic              lastOwner, lastOwnerNext;
    logic [BCNT_W-1:0] burstCnt, burstCntNext;
    logic              grant0, grant1;
    logic              win;

    assign win       = Blank | ~BLANK_ONLY;
    assign Req0Ready = grant0;
    assign Req1Ready = grant1;

    // Arbitration state register: owner, last owner for tie-break, burst count.
    always_ff @(posedge PixelClkSrc) begin
        if (Rst) begin
            state     <= ST_IDLE;
            lastOwner <= 1'b1;
            burstCnt  <= '0;
        end else begin
            state     <= stateNext;
            lastOwner <= lastOwnerNext;
            burstCnt  <= burstCntNext;
        end
    end

    // Grant decision and next state; everything holds while the window is shut.
    always_comb begin
        stateNext     = state;
        lastOwnerNext = lastOwner;
        burstCntNext  = burstCnt;
        grant0        = 1'b0;
        grant1        = 1'b0;
        if (win && !Rst) begin
            unique case (state)
                ST_IDLE: begin
                    // Tie goes to whoever did not own last.
                    if (Req0Valid && (!Req1Valid || lastOwner)) begin
                        grant0        = 1'b1;
                        stateNext     = ST_OWN0;
                        burstCntNext  = BCNT_W'(1);
                        lastOwnerNext = 1'b0;
                    end else if (Req1Valid) begin
                        grant1        = 1'b1;
                        stateNext     = ST_OWN1;
                        burstCntNext  = BCNT_W'(1);
                        lastOwnerNext = 1'b1;
                    end
                end
                ST_OWN0: begin
                    if (Req0Valid && (!Req1Valid || burstCnt < BurstMaxC)) begin
                        grant0       = 1'b1;
                        burstCntNext = satInc(burstCnt, BurstMaxC);
                    end else if (Req1Valid) begin
                        grant1        = 1'b1;
                        stateNext     = ST_OWN1;
                        burstCntNext  = BCNT_W'(1);
                        lastOwnerNext = 1'b1;
                    end else begin
                        stateNext    = ST_IDLE;
                        burstCntNext = '0;
                    end
                end
                ST_OWN1: begin
                    if (Req1Valid && (!Req0Valid || burstCnt < BurstMaxC)) begin
                        grant1       = 1'b1;
                        burstCntNext = satInc(burstCnt, BurstMaxC);
                    end else if (Req0Valid) begin
                        grant0        = 1'b1;
                        stateNext     = ST_OWN0;
                        burstCntNext  = BCNT_W'(1);
                        lastOwnerNext = 1'b0;
                    end else begin
                        stateNext    = ST_IDLE;
                        burstCntNext = '0;
                    end
                end
                default: begin
                    stateNext    = ST_IDLE;
                    burstCntNext = '0;
                end
            endcase
        end
    end

    // Registered write port: strobe for one cycle after each transfer, hold addr/data otherwise.
    always_ff @(posedge PixelClkSrc) begin
        if (Rst) begin
            WrEnable <= 1'b0;
            WrAddr   <= '0;
            WrData   <= '0;
        end else begin
            WrEnable <= grant0 | grant1;
            if (grant0) begin
                WrAddr <= Req0Addr;
                WrData <= Req0Data;
            end else if (grant1) begin
                WrAddr <= Req1Addr;
                WrData <= Req1Data;
            end
        end
    end

endmodule

// File: tb/tb_vbuffer_write_arbiter.sv
// Bench for vbuffer_write_arbiter: directed vector table for the named corner
// cases, then randomized traffic checked against a behavioural model.
module tb_vbuffer_write_arbiter;

    localparam int AW   = 2;
    localparam int BW   = 6;
    localparam int BMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1, blank = 1'b1, v0 = 1'b1, v1 = 1'b1;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [BW-1:0] d0 = '0, d1 = '0;
    logic          r0, r1, we;
    logic [AW-1:0] wa;
    logic [BW-1:0] wd;

    int nChk = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    vbuffer_write_arbiter #(.AWIDTH(AW), .BPP(BW), .BLANK_ONLY(1'b1), .BURST_MAX(BMAX)) dut (
        .PixelClkSrc(clk), .Rst(rst), .Blank(blank),
        .Req0Valid(v0), .Req0Ready(r0), .Req0Addr(a0), .Req0Data(d0),
        .Req1Valid(v1), .Req1Ready(r1), .Req1Addr(a1), .Req1Data(d1),
        .WrEnable(we), .WrAddr(wa), .WrData(wd)
    );

    typedef struct {
        logic          rst, blank, v0, v1;
        logic [AW-1:0] a0;
        logic [BW-1:0] d0;
        logic          r0, r1, we;
        logic [AW-1:0] wa;
        logic [BW-1:0] wd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rs, input logic bl, input logic q0, input logic q1,
                       input logic [AW-1:0] ad, input logic [BW-1:0] dt,
                       input logic e0, input logic e1, input logic ew,
                       input logic [AW-1:0] ea, input logic [BW-1:0] ed);
        vec_t v;
        v.rst = rs; v.blank = bl; v.v0 = q0; v.v1 = q1; v.a0 = ad; v.d0 = dt;
        v.r0 = e0; v.r1 = e1; v.we = ew; v.wa = ea; v.wd = ed;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Behavioural reference: who owns, how long, and who had the port last.
    int            mOwner, mCnt, mLast;
    logic          mWe;
    logic [AW-1:0] mA;
    logic [BW-1:0] mD;

    function automatic int refGrant();
        if (rst || !blank) return -1;
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (mOwner < 0) return 1 - mLast;
        return (mCnt < BMAX) ? mOwner : 1 - mOwner;
    endfunction

    task automatic refStep(input int g);
        if (rst) begin
            mOwner = -1; mCnt = 0; mLast = 1; mWe = 1'b0; mA = '0; mD = '0;
        end else if (!blank) begin
            mWe = 1'b0;
        end else if (g < 0) begin
            mWe = 1'b0; mOwner = -1; mCnt = 0;
        end else begin
            mWe = 1'b1;
            mA  = (g == 1) ? a1 : a0;
            mD  = (g == 1) ? d1 : d0;
            if (g == mOwner) mCnt = (mCnt + 1 > BMAX) ? BMAX : mCnt + 1;
            else begin mOwner = g; mCnt = 1; mLast = g; end
        end
    endtask

    initial begin
        // Directed vectors; a1/d1 stay at 3/'h33 throughout.
        add(1,1,1,1, 1,'h11, 0,0,0, 0,'h00);
        add(1,1,1,1, 1,'h11, 0,0,0, 0,'h00);
        add(1,1,1,1, 1,'h11, 0,0,0, 0,'h00);
        add(0,1,1,1, 1,'h11, 1,0,0, 0,'h00);   // burst: 0,0,0,0,1,1,1,1,0
        add(0,1,1,1, 1,'h11, 1,0,1, 1,'h11);
        add(0,1,1,1, 1,'h11, 1,0,1, 1,'h11);
        add(0,1,1,1, 1,'h11, 1,0,1, 1,'h11);
        add(0,1,1,1, 1,'h11, 0,1,1, 1,'h11);
        add(0,1,1,1, 1,'h11, 0,1,1, 3,'h33);
        add(0,1,1,1, 1,'h11, 0,1,1, 3,'h33);
        add(0,1,1,1, 1,'h11, 0,1,1, 3,'h33);
        add(0,1,1,1, 1,'h11, 1,0,1, 3,'h33);
        add(0,1,0,0, 1,'h11, 0,0,1, 1,'h11);
        add(0,1,0,0, 1,'h11, 0,0,0, 1,'h11);
        add(0,1,0,1, 1,'h11, 0,1,0, 1,'h11);   // Req1 bursts, idles, then tie
        add(0,1,0,1, 1,'h11, 0,1,1, 3,'h33);
        add(0,1,0,0, 1,'h11, 0,0,1, 3,'h33);
        add(0,1,0,0, 1,'h11, 0,0,0, 3,'h33);
        add(0,1,1,1, 1,'h11, 1,0,0, 3,'h33);
        add(0,1,0,0, 1,'h11, 0,0,1, 1,'h11);
        add(0,0,1,0, 2,'h2A, 0,0,0, 1,'h11);   // blank gating
        add(0,1,1,0, 2,'h2A, 1,0,0, 1,'h11);
        add(0,1,0,0, 2,'h2A, 0,0,1, 2,'h2A);
        add(0,1,0,1, 1,'h11, 0,1,0, 2,'h2A);   // window close mid-burst
        add(0,1,1,1, 1,'h11, 0,1,1, 3,'h33);
        add(0,0,1,1, 1,'h11, 0,0,1, 3,'h33);
        add(0,0,1,1, 1,'h11, 0,0,0, 3,'h33);
        add(0,1,1,1, 1,'h11, 0,1,0, 3,'h33);
        add(0,1,1,1, 1,'h11, 0,1,1, 3,'h33);
        add(0,1,1,1, 1,'h11, 1,0,1, 3,'h33);
        add(1,1,1,1, 1,'h11, 0,0,1, 1,'h11);   // reset mid-burst
        add(0,1,1,1, 1,'h11, 1,0,0, 0,'h00);
        add(0,1,0,0, 1,'h11, 0,0,1, 1,'h11);

        a1 = 2'd3; d1 = 6'h33; a0 = 2'd1; d0 = 6'h11;
        @(posedge clk);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; blank = tbl[i].blank; v0 = tbl[i].v0; v1 = tbl[i].v1;
            a0 = tbl[i].a0; d0 = tbl[i].d0;
            #4;
            chk($sformatf("vec%0d {r0,r1,we,wa,wd}", i), {21'd0, r0, r1, we, wa, wd},
                {21'd0, tbl[i].r0, tbl[i].r1, tbl[i].we, tbl[i].wa, tbl[i].wd});
        end

        // Randomized traffic against the model; requesters hold addr/data while stalled.
        begin
            logic pend0, pend1;
            int   g;
            pend0 = 1'b0; pend1 = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                @(posedge clk); #1;
                rst   = (i < 2) || ($urandom % 150 == 0);
                blank = ($urandom % 4 != 0);
                if (pend0 && ($urandom % 8 != 0)) v0 = 1'b1;
                else begin v0 = ($urandom % 3 != 0); a0 = AW'($urandom); d0 = BW'($urandom); end
                if (pend1 && ($urandom % 8 != 0)) v1 = 1'b1;
                else begin v1 = ($urandom % 3 != 0); a1 = AW'($urandom); d1 = BW'($urandom); end
                #4;
                g = refGrant();
                if (i >= 1) begin
                    chk("rand ready", {30'd0, r0, r1}, {30'd0, g == 0, g == 1});
                    chk("rand write", {23'd0, we, wa, wd}, {23'd0, mWe, mA, mD});
                end
                refStep(g);
                pend0 = v0 && (g != 0) && !rst;
                pend1 = v1 && (g != 1) && !rst;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
